// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream and instruction-memory write bundle for the
// boot loader.
//   start       : one-cycle load request              (master -> loader)
//   byte_in     : incoming program byte               (master -> loader)
//   byte_valid  : byte_in holds a valid byte          (master -> loader)
//   byte_ready  : loader accepts a byte this cycle    (loader -> master)
//   wr_en       : imem write strobe, one per word     (loader -> master)
//   wr_addr     : byte address of the written word    (loader -> master)
//   wr_data     : instruction word being written      (loader -> master)
//   cpu_hold    : keeps the CPU's PC frozen           (loader -> master)
//   done / err  : load finished / load aborted        (loader -> master)
interface imem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- receives a program over a byte stream and writes it into
// instruction memory while holding the CPU.
// Stream format: 16-bit word count N (MSB first), then N 32-bit words, each
// MSB first. Words are written to BASE_ADDR, BASE_ADDR+4, ...
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imem_loader_if.slave (start, byte stream, imem write, status)
// Parameters: BASE_ADDR (first word address), DEPTH (capacity in words),
//   TIMEOUT (max idle cycles between accepted bytes while loading).
// All outputs are registered and derived from the next state, so they line
// up exactly with the state they describe.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned TIMEOUT   = 1000
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_LOAD, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   n_q, n_d;               // word count from header
  logic [15:0]   word_cnt_q, word_cnt_d; // words written so far
  logic [1:0]    byte_cnt_q, byte_cnt_d; // bytes of current word received
  logic [TW-1:0] tmo_q, tmo_d;           // idle cycles since last byte
  logic [23:0]   shift_q, shift_d;       // first three bytes of a word
  logic [31:0]   addr_q, addr_d;         // address of the next word
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          byte_ready_q, byte_ready_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic [15:0]   n_val;
  logic [TW-1:0] tmo_inc;
  logic [15:0]   word_inc;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    accept   = bus.byte_valid && byte_ready_q;
    n_val    = {n_q[15:8], bus.byte_in};
    tmo_inc  = tmo_q + TW'(1);
    word_inc = word_cnt_q + 16'd1;

    // Idle-gap watchdog shared by the three byte-receiving states. A timeout
    // drops any partial word: byte_cnt is cleared on the next start.
    if (state_q inside {S_HDR_HI, S_HDR_LO, S_LOAD}) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_inc;
        if (tmo_inc == TW'(TIMEOUT)) state_d = S_ERR;
      end
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d    = S_HDR_HI;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          tmo_d      = '0;
          addr_d     = BASE_ADDR;
          wr_addr_d  = BASE_ADDR;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d[15:8] = bus.byte_in;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d = n_val;
          if (n_val == 16'd0)            state_d = S_DONE;
          else if (32'(n_val) > DEPTH)   state_d = S_ERR;
          else                           state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            wr_data_d  = {shift_q, bus.byte_in};
            wr_addr_d  = addr_q;
            byte_cnt_d = '0;
            state_d    = S_WRITE;
          end else begin
            shift_d    = {shift_q[15:0], bus.byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_inc;
        addr_d     = addr_q + 32'd4;
        state_d    = (word_inc == n_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = state_d inside {S_HDR_HI, S_HDR_LO, S_LOAD};
    wr_en_d      = (state_d == S_WRITE);
    cpu_hold_d   = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      shift_q      <= '0;
      addr_q       <= BASE_ADDR;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader.
// A header table drives randomized program streams; the expected write list
// comes from a stream-level model (N from the header, words from byte
// groups). Hand sequences cover the fixed example, timeout and mid-load reset.
module tb_imem_loader;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned TMO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] got_q[$];   // observed {wr_addr, wr_data}
  logic [63:0] exp_q[$];   // model {addr, data}
  logic [7:0]  stream[$];  // bytes to send

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    bit         gaps;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write collector; also checks that no byte can be taken during WRITE.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      got_q.push_back({bus.wr_addr, bus.wr_data});
      check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
    end
  end

  // Called and returns at a negedge, after the byte has been accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    budget = 0;
    while (bus.byte_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("byte_accept_wait", 64'(budget), 64'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Stream-level reference: header gives N; a legal N yields N words built
  // from consecutive byte groups, placed at BASE + 4*k.
  function automatic void build_model();
    int unsigned n;
    exp_q.delete();
    n = 32'({stream[0], stream[1]});
    if (n == 0 || n > DEPTH) return;
    for (int k = 0; k < int'(n); k++)
      exp_q.push_back({BASE + 32'(4 * k), stream[2+4*k], stream[3+4*k],
                       stream[4+4*k], stream[5+4*k]});
  endfunction

  function automatic logic [63:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic compare_writes(input string name);
    check({name, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_write%0d", name, i), got_at(i), exp_q[i]);
  endtask

  task automatic send_stream(input bit gaps);
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], gaps);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({name, "_wr_en"},      64'(bus.wr_en),      64'd0);
    check({name, "_wr_addr"},    64'(bus.wr_addr),    64'(BASE));
    check({name, "_wr_data"},    64'(bus.wr_data),    64'd0);
    check({name, "_cpu_hold"},   64'(bus.cpu_hold),   64'd1);
    check({name, "_done"},       64'(bus.done),       64'd0);
    check({name, "_err"},        64'(bus.err),        64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;

    vecs[0] = '{8'h00, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h03, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", 64'(bus.cpu_hold), 64'd1);

    // Fixed example stream
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h01, 8'h00, 8'h04};
    got_q.delete();
    pulse_start();
    send_stream(1'b0);
    check("basic_wr_en_latency", 64'(bus.wr_en), 64'd1);
    @(negedge clk);
    check("basic_count", 64'(got_q.size()), 64'd2);
    check("basic_word0", got_at(0), {32'h0000_0000, 32'h2008_0005});
    check("basic_word1", got_at(1), {32'h0000_0004, 32'hAC01_0004});
    check("basic_done", 64'(bus.done), 64'd1);
    check("basic_cpu_hold", 64'(bus.cpu_hold), 64'd0);

    // Table-driven headers with random payloads
    foreach (vecs[v]) begin
      stream.delete();
      stream.push_back(vecs[v].hi);
      stream.push_back(vecs[v].lo);
      n = 32'({vecs[v].hi, vecs[v].lo});
      if (vecs[v].exp_done)
        for (int i = 0; i < int'(n) * 4; i++) stream.push_back(8'($urandom));
      build_model();
      got_q.delete();
      pulse_start();
      send_stream(vecs[v].gaps);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_err", v), 64'(bus.err), 64'd1);
        check($sformatf("v%0d_hold", v), 64'(bus.cpu_hold), 64'd1);
        check($sformatf("v%0d_ready", v), 64'(bus.byte_ready), 64'd0);
      end else if (n == 0) begin
        check($sformatf("v%0d_done", v), 64'(bus.done), 64'd1);
      end else begin
        check($sformatf("v%0d_wr_en_latency", v), 64'(bus.wr_en), 64'd1);
        @(negedge clk);
        check($sformatf("v%0d_done", v), 64'(bus.done), 64'd1);
        check($sformatf("v%0d_hold", v), 64'(bus.cpu_hold), 64'd0);
      end
      check($sformatf("v%0d_done_flag", v), 64'(bus.done), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_err_flag", v), 64'(bus.err), 64'(vecs[v].exp_err));
      compare_writes($sformatf("v%0d", v));
    end

    // Timeout after three bytes of the first word
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    got_q.delete();
    pulse_start();
    send_stream(1'b0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_err_early", 64'(bus.err), 64'd0);
    @(negedge clk);
    check("tmo_err", 64'(bus.err), 64'd1);
    check("tmo_hold", 64'(bus.cpu_hold), 64'd1);
    check("tmo_no_write", 64'(got_q.size()), 64'd0);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h44;
    repeat (5) @(negedge clk);
    bus.byte_valid = 1'b0;
    check("tmo_err_sticky", 64'(bus.err), 64'd1);
    check("tmo_still_no_write", 64'(got_q.size()), 64'd0);

    // Recovery load, with a start pulse mid-load that must be ignored
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h02);
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    build_model();
    got_q.delete();
    pulse_start();
    check("recover_err_cleared", 64'(bus.err), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
    pulse_start();
    for (int i = 4; i < stream.size(); i++) send_byte(stream[i], 1'b1);
    @(negedge clk);
    check("recover_done", 64'(bus.done), 64'd1);
    compare_writes("recover");

    // Reset after the second byte of word 1
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h01, 8'h00, 8'h04};
    exp_q.delete();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst_async");
    bus.byte_valid = 1'b1;
    bus.byte_in    = stream[8];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.byte_in = stream[9];
    repeat (5) @(negedge clk);
    bus.byte_valid = 1'b0;
    check("midrst_idle_ready", 64'(bus.byte_ready), 64'd0);
    check("midrst_idle_hold", 64'(bus.cpu_hold), 64'd1);
    check("midrst_idle_done", 64'(bus.done), 64'd0);
    compare_writes("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter DEPTH, default 256, instruction-memory capacity in 32-bit words.
REQ-003 Parameter TIMEOUT, default 1000, maximum idle cycles between accepted bytes during a load.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle load request.
REQ-007 byte_in  input  8  incoming program byte.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 wr_addr  output  32  byte address of the word being written.
REQ-012 wr_data  output  32  instruction word being written.
REQ-013 cpu_hold  output  1  holds the CPU's PC while high.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  load aborted: size too large or timeout.

Function
REQ-016 States: IDLE, HDR_HI, HDR_LO, LOAD, WRITE, DONE, ERR.
REQ-017 A byte is accepted only in a cycle where byte_valid and byte_ready are both 1; byte_in is ignored in all other cycles.
REQ-018 byte_ready shall be 1 only in HDR_HI, HDR_LO and LOAD.
REQ-019 IDLE/DONE/ERR with start=1 -> HDR_HI, clearing err, done, the word counter, the byte counter and the timeout counter, and setting wr_addr to BASE_ADDR.
REQ-020 start in HDR_HI, HDR_LO, LOAD or WRITE shall be ignored.
REQ-021 HDR_HI: an accepted byte becomes N[15:8] -> HDR_LO.
REQ-022 HDR_LO: an accepted byte becomes N[7:0].
REQ-023 In HDR_LO, when the accepted byte makes N = 0 -> DONE.
REQ-024 In HDR_LO, when the accepted byte makes N > DEPTH -> ERR.
REQ-025 In HDR_LO, when the accepted byte makes 0 < N <= DEPTH -> LOAD.
REQ-026 LOAD: accepted bytes shift into the word MSB-first (first byte lands in bits 31:24).
REQ-027 LOAD: the 4th accepted byte -> WRITE.
REQ-028 WRITE lasts exactly one cycle, with wr_en=1, wr_data=the assembled word and wr_addr=BASE_ADDR+4*k, where k is the 0-based word index.
REQ-029 Leaving WRITE, the word counter increments and wr_addr advances by 4 (32-bit wrap).
REQ-030 Leaving WRITE, when the incremented word count equals N -> DONE, otherwise -> LOAD.
REQ-031 wr_en shall be 0 in every state except WRITE.
REQ-032 wr_addr and wr_data hold their last values outside WRITE.
REQ-033 Timeout counter: it increments each cycle in HDR_HI, HDR_LO and LOAD with no accepted byte.
REQ-034 Timeout counter: it clears on every accepted byte and on entry to HDR_HI.
REQ-035 When the timeout counter reaches TIMEOUT -> ERR; any partial word is discarded and never written.
REQ-036 cpu_hold shall be 0 only in DONE.
REQ-037 done shall be 1 only in DONE.
REQ-038 err shall be 1 only in ERR.
REQ-039 ERR is left only by start or rst.
REQ-040 Latency: wr_en asserts in the cycle immediately after the 4th byte of a word is accepted.
REQ-041 Latency: done asserts in the cycle after the WRITE of the last word, or in the cycle after the HDR_LO byte when N = 0.

Reset
REQ-042 rst=1 forces state IDLE immediately, independent of clk.
REQ-043 Reset values: byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0, all counters 0.
REQ-044 rst asserted mid-load aborts the load with no further wr_en pulse; after reset release the loader waits in IDLE for start.

Verification
REQ-045 Basic load: start, then bytes 00 02 20 08 00 05 AC 01 00 04 -> exactly two wr_en pulses: (addr 0x0, data 0x20080005), then (addr 0x4, data 0xAC010004); then done=1 and cpu_hold=0.
REQ-046 Back-pressure and gaps: byte_valid toggled randomly with gaps < TIMEOUT -> identical writes to REQ-045; byte_ready=0 during each WRITE cycle; no byte is lost or duplicated.
REQ-047 Oversize: header 01 01 (N=257) with DEPTH=256 -> err=1 one cycle after the second header byte; no wr_en pulse; cpu_hold stays 1.
REQ-048 Timeout: 3 bytes of the first word, then byte_valid=0 for TIMEOUT cycles -> err=1; no wr_en pulse; a following start plus a valid stream loads correctly.
REQ-049 Empty load: header 00 00 -> done=1 in the next cycle; zero wr_en pulses.
REQ-050 Mid-load reset: rst pulsed after the 2nd word's 2nd byte -> all outputs at reset values asynchronously; only word 0 was written.
